// File: rtl/sim_run_controller.sv
// -----------------------------------------------------------------------------
// sim_run_controller
//
// Reusable run controller for simulation benches. It holds the DUT in reset
// for RESET_CYCLES cycles after the controller's own reset is released, counts
// RUN cycles, and collects per-channel completion and error indications. It
// waits DRAIN_CYCLES cycles after the end-of-run decision and then reports
// pass / fail / timeout. Optionally it ends the simulation.
//
// Ports:
//   clock        in   single clock, all state updates on posedge
//   rst          in   synchronous active-high reset of the controller
//   done_in      in   [N_DONE] per-channel completion pulses (RUN only)
//   error_in     in   DUT error indication (RUN only)
//   dut_rst      out  synchronous active-high reset for the DUT
//   cycle_count  out  [CNT_W] RUN-cycle counter, frozen at the exit cycle
//   state        out  [2] HOLD=0, RUN=1, DRAIN=2, FINISHED=3
//   running      out  high while in RUN
//   done_seen    out  [N_DONE] sticky capture of done_in
//   finished     out  high in FINISHED
//   pass         out  all channels done, no error (only while finished)
//   fail         out  error seen (only while finished)
//   timeout      out  MAX_CYCLES reached first (only while finished)
//
// All outputs are registered. They are computed from the next-state values,
// so they always agree with the state output in the same cycle.
// -----------------------------------------------------------------------------
module sim_run_controller #(
    parameter int unsigned MAX_CYCLES   = 200,
    parameter int unsigned RESET_CYCLES = 2,
    parameter int unsigned DRAIN_CYCLES = 4,
    parameter int unsigned N_DONE       = 1,
    parameter int unsigned CNT_W        = 32,
    parameter bit          CALL_FINISH  = 1'b1
) (
    input  logic              clock,
    input  logic              rst,
    input  logic [N_DONE-1:0] done_in,
    input  logic              error_in,
    output logic              dut_rst,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [1:0]        state,
    output logic              running,
    output logic [N_DONE-1:0] done_seen,
    output logic              finished,
    output logic              pass,
    output logic              fail,
    output logic              timeout
);

    typedef enum logic [1:0] {
        ST_HOLD     = 2'd0,
        ST_RUN      = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_FINISHED = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        RES_NONE    = 2'd0,
        RES_PASS    = 2'd1,
        RES_FAIL    = 2'd2,
        RES_TIMEOUT = 2'd3
    } result_t;

    // Hold and drain counters only need to reach COUNT-1.
    localparam int unsigned HOLD_W  = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    // RESET_CYCLES of 0 and 1 both leave HOLD on the first edge with rst low,
    // because HOLD is already occupied for the cycle that follows the reset edge.
    localparam logic [HOLD_W-1:0]  HOLD_LAST  =
        HOLD_W'((RESET_CYCLES > 0) ? RESET_CYCLES - 1 : 0);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST =
        DRAIN_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0]   MAX_CNT    = CNT_W'(MAX_CYCLES);

    // The counter must be able to hold MAX_CYCLES, since it never wraps.
    if ((64'(MAX_CYCLES) >> CNT_W) != 64'd0) begin : g_bad_cnt_w
        $error("sim_run_controller: CNT_W=%0d cannot hold MAX_CYCLES=%0d", CNT_W, MAX_CYCLES);
    end
    if (N_DONE == 0) begin : g_bad_n_done
        $error("sim_run_controller: N_DONE must be at least 1");
    end

    state_t              state_q, state_d;
    result_t             res_q, res_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [DRAIN_W-1:0]  drain_cnt_q, drain_cnt_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [N_DONE-1:0]   done_seen_q, done_seen_d;
    logic                dut_rst_q, dut_rst_d;
    logic                running_q, running_d;
    logic                finished_q, finished_d;
    logic                pass_q, pass_d;
    logic                fail_q, fail_d;
    logic                timeout_q, timeout_d;
    logic                done_all;
    logic                run_exit;

    always_comb begin
        state_d     = state_q;
        res_d       = res_q;
        hold_cnt_d  = hold_cnt_q;
        drain_cnt_d = drain_cnt_q;
        count_d     = count_q;
        done_seen_d = done_seen_q;
        run_exit    = 1'b0;
        // Includes this cycle's pulses so a last done on the exit cycle counts.
        done_all    = &(done_seen_q | done_in);

        case (state_q)
            ST_HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d    = ST_RUN;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            ST_RUN: begin
                done_seen_d = done_seen_q | done_in;
                // Priority: error > done > timeout.
                if (error_in) begin
                    res_d    = RES_FAIL;
                    run_exit = 1'b1;
                end else if (done_all) begin
                    res_d    = RES_PASS;
                    run_exit = 1'b1;
                end else if (count_q == MAX_CNT) begin
                    res_d    = RES_TIMEOUT;
                    run_exit = 1'b1;
                end else begin
                    count_d  = count_q + CNT_W'(1);
                end
                if (run_exit) begin
                    state_d     = (DRAIN_CYCLES == 0) ? ST_FINISHED : ST_DRAIN;
                    drain_cnt_d = '0;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_q == DRAIN_LAST) begin
                    state_d = ST_FINISHED;
                end else begin
                    drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
                end
            end
            default: begin
                state_d = ST_FINISHED;
            end
        endcase

        dut_rst_d  = (state_d == ST_HOLD);
        running_d  = (state_d == ST_RUN);
        finished_d = (state_d == ST_FINISHED);
        pass_d     = finished_d && (res_d == RES_PASS);
        fail_d     = finished_d && (res_d == RES_FAIL);
        timeout_d  = finished_d && (res_d == RES_TIMEOUT);
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q     <= ST_HOLD;
            res_q       <= RES_NONE;
            hold_cnt_q  <= '0;
            drain_cnt_q <= '0;
            count_q     <= '0;
            done_seen_q <= '0;
            dut_rst_q   <= 1'b1;
            running_q   <= 1'b0;
            finished_q  <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            res_q       <= res_d;
            hold_cnt_q  <= hold_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            count_q     <= count_d;
            done_seen_q <= done_seen_d;
            dut_rst_q   <= dut_rst_d;
            running_q   <= running_d;
            finished_q  <= finished_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            timeout_q   <= timeout_d;
        end
    end

    assign state       = state_q;
    assign dut_rst     = dut_rst_q;
    assign cycle_count = count_q;
    assign running     = running_q;
    assign done_seen   = done_seen_q;
    assign finished    = finished_q;
    assign pass        = pass_q;
    assign fail        = fail_q;
    assign timeout     = timeout_q;

`ifndef SYNTHESIS
    // Simulation-only: end the run on the edge that enters FINISHED.
    if (CALL_FINISH) begin : g_finish
        always_ff @(posedge clock) begin
            if (!rst && state_d == ST_FINISHED && state_q != ST_FINISHED) begin
                $display("sim_run_controller: state=FINISHED cycle_count=%0d result=%s",
                         count_d,
                         (res_d == RES_PASS) ? "pass" :
                         (res_d == RES_FAIL) ? "fail" : "timeout");
                $finish;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sim_run_controller.sv
// -----------------------------------------------------------------------------
// Bench for sim_run_controller. Three instances share one clock:
//   u_a : default parameters (N_DONE=1), simulation end disabled
//   u_b : N_DONE=3, otherwise defaults
//   u_c : RESET_CYCLES=0, DRAIN_CYCLES=0, MAX_CYCLES=5, CNT_W=4
// Inputs change and outputs are sampled on the falling edge.
// Expected end-of-run words are {pass,fail,timeout,cycle_count[31:0],done_seen[2:0]}.
// -----------------------------------------------------------------------------
module tb_sim_run_controller;

    localparam int RW = 38;
    localparam logic [1:0] S_HOLD  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_FIN   = 2'd3;

    logic clock;

    logic        rst_a, done_a, err_a;
    logic        dut_rst_a, running_a, done_seen_a, finished_a, pass_a, fail_a, timeout_a;
    logic [31:0] cycle_count_a;
    logic [1:0]  state_a;

    logic        rst_b, err_b;
    logic [2:0]  done_b, done_seen_b;
    logic        dut_rst_b, running_b, finished_b, pass_b, fail_b, timeout_b;
    logic [31:0] cycle_count_b;
    logic [1:0]  state_b;

    logic        rst_c, done_c, err_c;
    logic        dut_rst_c, running_c, done_seen_c, finished_c, pass_c, fail_c, timeout_c;
    logic [3:0]  cycle_count_c;
    logic [1:0]  state_c;

    logic [RW-1:0] exp_q[$];
    int n_checks;
    int n_fail;

    sim_run_controller #(.CALL_FINISH(1'b0)) u_a (
        .clock(clock), .rst(rst_a), .done_in(done_a), .error_in(err_a),
        .dut_rst(dut_rst_a), .cycle_count(cycle_count_a), .state(state_a),
        .running(running_a), .done_seen(done_seen_a), .finished(finished_a),
        .pass(pass_a), .fail(fail_a), .timeout(timeout_a));

    sim_run_controller #(.N_DONE(3), .CALL_FINISH(1'b0)) u_b (
        .clock(clock), .rst(rst_b), .done_in(done_b), .error_in(err_b),
        .dut_rst(dut_rst_b), .cycle_count(cycle_count_b), .state(state_b),
        .running(running_b), .done_seen(done_seen_b), .finished(finished_b),
        .pass(pass_b), .fail(fail_b), .timeout(timeout_b));

    sim_run_controller #(.MAX_CYCLES(5), .RESET_CYCLES(0), .DRAIN_CYCLES(0),
                         .CNT_W(4), .CALL_FINISH(1'b0)) u_c (
        .clock(clock), .rst(rst_c), .done_in(done_c), .error_in(err_c),
        .dut_rst(dut_rst_c), .cycle_count(cycle_count_c), .state(state_c),
        .running(running_c), .done_seen(done_seen_c), .finished(finished_c),
        .pass(pass_c), .fail(fail_c), .timeout(timeout_c));

    // ---------------- clock ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- driver helpers ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Reset u_b, release it and wait (bounded) for RUN.
    task automatic start_b(input bit noise, output int hold_edges);
        rst_b = 1'b1; done_b = 3'b000; err_b = 1'b0;
        @(negedge clock);
        rst_b = 1'b0;
        if (noise) begin
            done_b = 3'b111;
            err_b  = 1'b1;
        end
        hold_edges = 0;
        for (int i = 0; i < 10 && state_b !== S_RUN; i++) begin
            @(negedge clock);
            hold_edges++;
        end
        done_b = 3'b000; err_b = 1'b0;
        n_checks++;
        if (state_b !== S_RUN || hold_edges != 2 || cycle_count_b !== 32'd0) begin
            n_fail++;
            $display("FAIL start_b: state=%0d hold_edges=%0d count=%0d, want state=1 hold_edges=2 count=0",
                     state_b, hold_edges, cycle_count_b);
        end
    endtask

    // Advance u_b until FINISHED (bounded), counting RUN and DRAIN cycles seen.
    task automatic wait_fin_b(output int n_run, output int n_drain);
        n_run = 0; n_drain = 0;
        for (int i = 0; i < 400 && finished_b !== 1'b1; i++) begin
            if (state_b == S_RUN) n_run++;
            if (state_b == S_DRAIN) n_drain++;
            @(negedge clock);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        n_checks++;
        if ({state_a, dut_rst_a, running_a, done_seen_a, finished_a, pass_a, fail_a, timeout_a} !== 9'b00_1_000000
            || cycle_count_a !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_a: flags=%b count=%0d, want flags=001000000 count=0",
                     {state_a, dut_rst_a, running_a, done_seen_a, finished_a, pass_a, fail_a, timeout_a}, cycle_count_a);
        end
        n_checks++;
        if ({state_b, dut_rst_b, running_b, done_seen_b, finished_b, pass_b, fail_b, timeout_b} !== 11'b00_1_0_000_0000
            || cycle_count_b !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_b: flags=%b count=%0d, want flags=00100000000 count=0",
                     {state_b, dut_rst_b, running_b, done_seen_b, finished_b, pass_b, fail_b, timeout_b}, cycle_count_b);
        end
    endtask

    task automatic test_timeout();
        int hold_edges, n_run, n_drain;
        bit bad;
        logic [RW-1:0] exp;
        hold_edges = 0; bad = 1'b0;
        rst_a = 1'b1; done_a = 1'b0; err_a = 1'b0;
        @(negedge clock);
        rst_a = 1'b0;
        for (int i = 0; i < 10 && state_a !== S_RUN; i++) begin
            @(negedge clock);
            hold_edges++;
            if (state_a == S_HOLD && dut_rst_a !== 1'b1) bad = 1'b1;
        end
        n_checks++;
        if (hold_edges != 2 || state_a !== S_RUN || dut_rst_a !== 1'b0 || bad) begin
            n_fail++;
            $display("FAIL timeout_hold: hold_edges=%0d state=%0d dut_rst=%b, want 2 1 0",
                     hold_edges, state_a, dut_rst_a);
        end
        exp_q.push_back({3'b001, 32'd200, 3'b000});
        n_run = 0; n_drain = 0; bad = 1'b0;
        for (int i = 0; i < 400 && finished_a !== 1'b1; i++) begin
            if (state_a == S_RUN) begin
                if (cycle_count_a !== 32'(n_run) || running_a !== 1'b1) bad = 1'b1;
                n_run++;
            end else if (state_a == S_DRAIN) begin
                n_drain++;
            end
            @(negedge clock);
        end
        n_checks++;
        if (n_run != 201 || n_drain != 4 || bad) begin
            n_fail++;
            $display("FAIL timeout_len: run=%0d drain=%0d count_ok=%b, want run=201 drain=4 count_ok=1",
                     n_run, n_drain, !bad);
        end
        n_checks++;
        if (state_a !== S_FIN || finished_a !== 1'b1 || running_a !== 1'b0 || dut_rst_a !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_state: state=%0d finished=%b running=%b dut_rst=%b, want 3 1 0 0",
                     state_a, finished_a, running_a, dut_rst_a);
        end
        exp = exp_q.pop_front();
        n_checks++;
        if ({pass_a, fail_a, timeout_a, cycle_count_a, 2'b00, done_seen_a} !== exp) begin
            n_fail++;
            $display("FAIL timeout_result: got %h want %h",
                     {pass_a, fail_a, timeout_a, cycle_count_a, 2'b00, done_seen_a}, exp);
        end
    endtask

    task automatic test_pass_multi();
        int hold_edges, n_run, n_drain;
        logic [RW-1:0] exp;
        start_b(1'b0, hold_edges);
        exp_q.push_back({3'b100, 32'd35, 3'b111});
        step(10);
        n_checks++;
        if (cycle_count_b !== 32'd10 || running_b !== 1'b1) begin
            n_fail++;
            $display("FAIL pass_count10: count=%0d running=%b, want 10 1", cycle_count_b, running_b);
        end
        done_b = 3'b001; step(1); done_b = 3'b000;
        n_checks++;
        if (done_seen_b !== 3'b001) begin
            n_fail++;
            $display("FAIL pass_seen1: done_seen=%b want 001", done_seen_b);
        end
        step(9);
        done_b = 3'b100; step(1); done_b = 3'b000;
        n_checks++;
        if (done_seen_b !== 3'b101 || cycle_count_b !== 32'd21) begin
            n_fail++;
            $display("FAIL pass_seen2: done_seen=%b count=%0d, want 101 21", done_seen_b, cycle_count_b);
        end
        step(14);
        done_b = 3'b010; step(1); done_b = 3'b000;
        n_checks++;
        if (state_b !== S_DRAIN || done_seen_b !== 3'b111 || cycle_count_b !== 32'd35 || pass_b !== 1'b0) begin
            n_fail++;
            $display("FAIL pass_exit: state=%0d done_seen=%b count=%0d pass=%b, want 2 111 35 0",
                     state_b, done_seen_b, cycle_count_b, pass_b);
        end
        err_b = 1'b1; // ignored during DRAIN
        wait_fin_b(n_run, n_drain);
        err_b = 1'b0;
        n_checks++;
        if (finished_b !== 1'b1 || n_drain != 4 || n_run != 0) begin
            n_fail++;
            $display("FAIL pass_drain: finished=%b drain=%0d run=%0d, want 1 4 0", finished_b, n_drain, n_run);
        end
        exp = exp_q.pop_front();
        n_checks++;
        if ({pass_b, fail_b, timeout_b, cycle_count_b, done_seen_b} !== exp) begin
            n_fail++;
            $display("FAIL pass_result: got %h want %h", {pass_b, fail_b, timeout_b, cycle_count_b, done_seen_b}, exp);
        end
    endtask

    task automatic test_error_priority();
        int hold_edges, n_run, n_drain;
        logic [RW-1:0] exp;
        // reset out of FINISHED clears every status output
        rst_b = 1'b1; step(1);
        n_checks++;
        if ({state_b, dut_rst_b, finished_b, pass_b, fail_b, timeout_b, done_seen_b} !== 11'b00_1_0000_000
            || cycle_count_b !== 32'd0) begin
            n_fail++;
            $display("FAIL err_reset_from_fin: flags=%b count=%0d, want 00100000000 0",
                     {state_b, dut_rst_b, finished_b, pass_b, fail_b, timeout_b, done_seen_b}, cycle_count_b);
        end
        start_b(1'b0, hold_edges);
        exp_q.push_back({3'b010, 32'd50, 3'b111});
        step(10);
        done_b = 3'b011; step(1); done_b = 3'b000;
        step(39);
        n_checks++;
        if (cycle_count_b !== 32'd50) begin
            n_fail++;
            $display("FAIL err_count50: count=%0d want 50", cycle_count_b);
        end
        done_b = 3'b100; err_b = 1'b1; step(1); done_b = 3'b000; err_b = 1'b0;
        wait_fin_b(n_run, n_drain);
        exp = exp_q.pop_front();
        n_checks++;
        if (finished_b !== 1'b1 || {pass_b, fail_b, timeout_b, cycle_count_b, done_seen_b} !== exp) begin
            n_fail++;
            $display("FAIL err_result: finished=%b got %h want %h",
                     finished_b, {pass_b, fail_b, timeout_b, cycle_count_b, done_seen_b}, exp);
        end
    endtask

    task automatic test_done_at_max();
        int hold_edges, n_run, n_drain;
        logic [RW-1:0] exp;
        start_b(1'b1, hold_edges); // done/error held high during HOLD must be ignored
        n_checks++;
        if (done_seen_b !== 3'b000 || running_b !== 1'b1) begin
            n_fail++;
            $display("FAIL max_hold_ignored: done_seen=%b running=%b, want 000 1", done_seen_b, running_b);
        end
        exp_q.push_back({3'b100, 32'd200, 3'b111});
        step(5);
        done_b = 3'b011; step(1); done_b = 3'b000;
        step(193);
        n_checks++;
        if (cycle_count_b !== 32'd199 || state_b !== S_RUN) begin
            n_fail++;
            $display("FAIL max_count199: count=%0d state=%0d, want 199 1", cycle_count_b, state_b);
        end
        step(1);
        done_b = 3'b100; step(1); done_b = 3'b000;
        wait_fin_b(n_run, n_drain);
        exp = exp_q.pop_front();
        n_checks++;
        if (finished_b !== 1'b1 || n_drain != 4 || {pass_b, fail_b, timeout_b, cycle_count_b, done_seen_b} !== exp) begin
            n_fail++;
            $display("FAIL max_result: finished=%b drain=%0d got %h want %h",
                     finished_b, n_drain, {pass_b, fail_b, timeout_b, cycle_count_b, done_seen_b}, exp);
        end
    endtask

    task automatic test_reset_mid_run();
        int hold_edges, n_run, n_drain;
        logic [RW-1:0] exp;
        start_b(1'b0, hold_edges);
        step(20);
        done_b = 3'b001; step(1); done_b = 3'b000;
        step(56);
        n_checks++;
        if (cycle_count_b !== 32'd77) begin
            n_fail++;
            $display("FAIL rst_count77: count=%0d want 77", cycle_count_b);
        end
        rst_b = 1'b1; step(1); rst_b = 1'b0;
        n_checks++;
        if ({state_b, dut_rst_b, running_b, finished_b, pass_b, fail_b, timeout_b, done_seen_b} !== 12'b00_1_0_0000_000
            || cycle_count_b !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_mid_run: flags=%b count=%0d, want 001000000000 0",
                     {state_b, dut_rst_b, running_b, finished_b, pass_b, fail_b, timeout_b, done_seen_b}, cycle_count_b);
        end
        hold_edges = 0;
        for (int i = 0; i < 10 && state_b !== S_RUN; i++) begin
            @(negedge clock);
            hold_edges++;
        end
        n_checks++;
        if (hold_edges != 2 || cycle_count_b !== 32'd0 || done_seen_b !== 3'b000) begin
            n_fail++;
            $display("FAIL rst_restart: hold_edges=%0d count=%0d done_seen=%b, want 2 0 000",
                     hold_edges, cycle_count_b, done_seen_b);
        end
        exp_q.push_back({3'b100, 32'd3, 3'b111});
        step(3);
        done_b = 3'b111; step(1); done_b = 3'b000;
        wait_fin_b(n_run, n_drain);
        exp = exp_q.pop_front();
        n_checks++;
        if (finished_b !== 1'b1 || {pass_b, fail_b, timeout_b, cycle_count_b, done_seen_b} !== exp) begin
            n_fail++;
            $display("FAIL rst_result: finished=%b got %h want %h",
                     finished_b, {pass_b, fail_b, timeout_b, cycle_count_b, done_seen_b}, exp);
        end
    endtask

    task automatic test_random_runs();
        int hold_edges, n_run, n_drain;
        int t0, t1, t2, te, tmax, ex;
        bit is_fail;
        logic [2:0] seen;
        logic [RW-1:0] exp;
        for (int r = 0; r < 4; r++) begin
            t0 = $urandom_range(0, 60);
            t1 = $urandom_range(0, 60);
            t2 = $urandom_range(0, 60);
            te = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 70)) : 1000;
            tmax = t0;
            if (t1 > tmax) tmax = t1;
            if (t2 > tmax) tmax = t2;
            is_fail = (te <= tmax);
            ex = is_fail ? te : tmax;
            seen = {t2 <= ex, t1 <= ex, t0 <= ex};
            exp_q.push_back({is_fail ? 3'b010 : 3'b100, 32'(ex), seen});
            start_b(1'b0, hold_edges);
            for (int c = 0; c < 300 && state_b == S_RUN; c++) begin
                done_b = {t2 == c, t1 == c, t0 == c};
                err_b  = (te == c);
                @(negedge clock);
            end
            done_b = 3'b000; err_b = 1'b0;
            wait_fin_b(n_run, n_drain);
            exp = exp_q.pop_front();
            n_checks++;
            if (finished_b !== 1'b1 || {pass_b, fail_b, timeout_b, cycle_count_b, done_seen_b} !== exp) begin
                n_fail++;
                $display("FAIL random_run%0d: t=%0d,%0d,%0d te=%0d got %h want %h",
                         r, t0, t1, t2, te, {pass_b, fail_b, timeout_b, cycle_count_b, done_seen_b}, exp);
            end
        end
    endtask

    task automatic test_short_config();
        bit bad;
        logic [RW-1:0] exp;
        bad = 1'b0;
        rst_c = 1'b1; done_c = 1'b0; err_c = 1'b0;
        step(1);
        n_checks++;
        if ({state_c, dut_rst_c, running_c, finished_c, timeout_c} !== 6'b00_1_000 || cycle_count_c !== 4'd0) begin
            n_fail++;
            $display("FAIL short_reset: flags=%b count=%0d, want 001000 0",
                     {state_c, dut_rst_c, running_c, finished_c, timeout_c}, cycle_count_c);
        end
        rst_c = 1'b0;
        step(1);
        n_checks++;
        if (state_c !== S_RUN || dut_rst_c !== 1'b0 || cycle_count_c !== 4'd0) begin
            n_fail++;
            $display("FAIL short_run_entry: state=%0d dut_rst=%b count=%0d, want 1 0 0",
                     state_c, dut_rst_c, cycle_count_c);
        end
        exp_q.push_back({3'b001, 32'd5, 3'b000});
        for (int k = 1; k <= 5; k++) begin
            step(1);
            if (state_c !== S_RUN || cycle_count_c !== 4'(k)) bad = 1'b1;
        end
        step(1);
        n_checks++;
        if (bad || state_c !== S_FIN || finished_c !== 1'b1) begin
            n_fail++;
            $display("FAIL short_finish: count_ok=%b state=%0d finished=%b, want 1 3 1",
                     !bad, state_c, finished_c);
        end
        done_c = 1'b1; err_c = 1'b1;
        step(3);
        done_c = 1'b0; err_c = 1'b0;
        exp = exp_q.pop_front();
        n_checks++;
        if (state_c !== S_FIN || {pass_c, fail_c, timeout_c, 28'd0, cycle_count_c, 2'b00, done_seen_c} !== exp) begin
            n_fail++;
            $display("FAIL short_result: state=%0d got %h want %h", state_c,
                     {pass_c, fail_c, timeout_c, 28'd0, cycle_count_c, 2'b00, done_seen_c}, exp);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        n_checks = 0; n_fail = 0;
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        done_a = 1'b0; done_b = 3'b000; done_c = 1'b0;
        err_a = 1'b0; err_b = 1'b0; err_c = 1'b0;
        step(3);
        test_reset();
        test_timeout();
        test_pass_multi();
        test_error_priority();
        test_done_at_max();
        test_reset_mid_run();
        test_random_runs();
        test_short_config();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sim_run_controller.md
Name: sim_run_controller

Overview:
- Reusable, parametrised run controller for simulation benches; replaces per-bench reset and watchdog logic.
- Sequences DUT reset for a configurable number of cycles, then counts run cycles.
- Collects per-channel completion and error indications, drains for a fixed window, reports pass/fail/timeout and optionally ends the simulation.
- Instantiated inside each bench alongside the DUT; the bench supplies the clock.

Parameters:
MAX_CYCLES, 200, run cycles allowed before timeout.
RESET_CYCLES, 2, cycles dut_rst is held high after rst deasserts (0 allowed).
DRAIN_CYCLES, 4, cycles between end-of-run decision and FINISHED (0 allowed).
N_DONE, 1, number of independent completion channels (>=1).
CNT_W, 32, width of cycle_count.
CALL_FINISH, 1, when 1 the block calls $finish on entering FINISHED (simulation-only code).

Ports:
clock  in  1  single clock; all state updates on posedge.
rst  in  1  synchronous, active-high reset of the controller.
done_in  in  N_DONE  per-channel completion; any single-cycle high is captured.
error_in  in  1  DUT error indication; sampled only in RUN.
dut_rst  out  1  reset driven to the DUT, synchronous active-high.
cycle_count  out  CNT_W  RUN-cycle counter.
state  out  2  HOLD=0, RUN=1, DRAIN=2, FINISHED=3.
running  out  1  high while in RUN.
done_seen  out  N_DONE  sticky per-channel capture of done_in.
finished  out  1  high in FINISHED.
pass  out  1  all channels done, no error; valid when finished=1.
fail  out  1  error_in seen; valid when finished=1.
timeout  out  1  MAX_CYCLES reached without done/error; valid when finished=1.

Behaviour:
- Reset (rst=1 at posedge): state=HOLD, dut_rst=1, cycle_count=0, hold/drain counters=0, done_seen=0, running=0, finished=0, pass=0, fail=0, timeout=0. Reset during any state, including mid-RUN or FINISHED, gives the same result.
- All outputs are registered; there is no combinational path from inputs to outputs.
- HOLD:
  - dut_rst=1. Counts cycles with rst=0.
  - After RESET_CYCLES such cycles, moves to RUN.
  - With RESET_CYCLES=0, RUN is entered on the first posedge with rst=0.
- RUN:
  - dut_rst=0, running=1.
  - The first RUN cycle has cycle_count=0; the count increments by 1 per RUN cycle.
  - done_seen <= done_seen | done_in each RUN cycle.
  - Exit conditions are evaluated every RUN cycle. Priority is error > done > timeout:
    - error_in=1 -> fail result.
    - (done_seen | done_in) all ones -> pass result.
    - cycle_count==MAX_CYCLES -> timeout result.
  - On exit, the chosen result is latched, cycle_count freezes, and the next state is DRAIN (or FINISHED if DRAIN_CYCLES=0).
  - Simultaneous events resolve by priority. Example: the last done arriving on the cycle cycle_count==MAX_CYCLES yields pass, not timeout.
- DRAIN:
  - dut_rst=0, running=0. done_in and error_in are ignored; done_seen holds.
  - After DRAIN_CYCLES cycles, moves to FINISHED.
- FINISHED:
  - finished=1. Exactly one of pass/fail/timeout is 1; all three are 0 in every other state.
  - The state holds until rst.
  - If CALL_FINISH=1, the block calls $finish once on the entering edge and prints state, cycle_count and result first.
- done_in and error_in are ignored in HOLD, DRAIN and FINISHED.
- cycle_count never wraps. CNT_W must hold MAX_CYCLES; otherwise an elaboration-time check errors.
- Latency, RUN entry to timeout FINISHED: MAX_CYCLES+1 RUN cycles + DRAIN_CYCLES.

Test Plan:
1. Defaults, N_DONE=1, done_in never asserted -> dut_rst high 2 cycles after rst low; RUN lasts 201 cycles (count 0..200); 4 DRAIN cycles; then finished=1, timeout=1, cycle_count=200.
2. N_DONE=3, CALL_FINISH=0. Pulse bit0 at count 10, bit2 at 20, bit1 at 35 -> done_seen goes 001, 101, 111; exit at count 35; pass=1 after 4 drain cycles; cycle_count frozen at 35.
3. error_in=1 and final done_in both at count 50 -> fail=1, pass=0, timeout=0.
4. Final done_in at count==MAX_CYCLES (200) -> pass=1, timeout=0.
5. rst pulsed at count 77 in RUN -> next cycle state=HOLD, dut_rst=1, cycle_count=0, done_seen=0, all status outputs 0; the sequence restarts correctly.
6. RESET_CYCLES=0, DRAIN_CYCLES=0, MAX_CYCLES=5 -> RUN on the first cycle after rst low; FINISHED immediately after the count==5 cycle with timeout=1. done_in pulsed in FINISHED -> no change.
